// File: rtl/bc_msg_pkg.sv
// bc_msg_pkg: broadcast message width and field offsets shared with the core wrapper
package bc_msg_pkg;
  localparam int BC_REGION_SIZE = 8192;
  localparam int BC_MSG_WIDTH   = 32 + 4 + $clog2(BC_REGION_SIZE) - 2;
  localparam int ADDR_LSB       = 0;
  localparam int ADDR_W         = BC_MSG_WIDTH - 36;
  localparam int STRB_LSB       = ADDR_W;
  localparam int DATA_LSB       = STRB_LSB + 4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter that starts searching one past the previous winner
module rr_arbiter #(
  parameter int PORTS = 4,
  parameter int IW    = $clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] req,
  input  logic             en,
  output logic [PORTS-1:0] grant,
  output logic [IW-1:0]    grant_idx
);
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic          found;
  // first requester in order last+1 .. last, wrapping
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = IW'((int'(last) + k) % PORTS);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant = (found && en) ? (PORTS'(1) << grant_idx) : '0;
  end
  // previous-winner pointer; reset value gives slot 0 first priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= IW'(PORTS - 1);
    else if (en && |req) last <= grant_idx;
endmodule

// File: rtl/bc_msg_arbiter.sv
// bc_msg_arbiter: per-core holding buffers, round-robin pick, one broadcast per cycle
module bc_msg_arbiter import bc_msg_pkg::*; #(
  parameter int CORE_COUNT    = 16,
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int MSG_WIDTH     = BC_MSG_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg,
  input  logic [CORE_COUNT-1:0]           s_msg_valid,
  output logic [CORE_COUNT-1:0]           s_msg_ready,
  output logic [MSG_WIDTH-1:0]            m_msg,
  output logic                            m_msg_valid,
  output logic [CORE_ID_WIDTH-1:0]        m_msg_src,
  output logic [31:0]                     msg_count
);
  logic [CORE_COUNT-1:0]    buf_valid, grant, load;
  logic [MSG_WIDTH-1:0]     buf_msg [CORE_COUNT];
  logic [CORE_ID_WIDTH-1:0] grant_idx;

  rr_arbiter #(.PORTS(CORE_COUNT), .IW(CORE_ID_WIDTH)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(buf_valid), .en(1'b1),
    .grant(grant), .grant_idx(grant_idx)
  );

  assign s_msg_ready = ~buf_valid | grant;
  assign load        = s_msg_valid & s_msg_ready;

  // holding buffers: a new load wins over the clear from a same-cycle grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buf_valid <= '0;
      for (int i = 0; i < CORE_COUNT; i++) buf_msg[i] <= '0;
    end else begin
      for (int i = 0; i < CORE_COUNT; i++)
        if (load[i]) begin
          buf_valid[i] <= 1'b1;
          buf_msg[i]   <= s_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end else if (grant[i]) buf_valid[i] <= 1'b0;
    end

  // broadcast register and running message count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_msg       <= '0;
      m_msg_src   <= '0;
      m_msg_valid <= 1'b0;
      msg_count   <= '0;
    end else if (|grant) begin
      m_msg       <= buf_msg[grant_idx];
      m_msg_src   <= grant_idx;
      m_msg_valid <= 1'b1;
      msg_count   <= msg_count + 32'd1;
    end else m_msg_valid <= 1'b0;
endmodule
